// File: rtl/fp_err_monitor.sv
// Measures fp32 ULP error between an exact and an approximate multiplier over a run of N pairs.
// Accepted pairs pass a two-stage key/difference pipeline before the statistics update.
module fp_err_monitor #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      exact,
  input  logic [31:0]      approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] nan_cnt,
  output logic [31:0]      max_ulp,
  output logic [ACC_W-1:0] sum_ulp
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] acc_cnt;
  logic             accept;

  logic [31:0] key_e_p0, key_a_p0;
  logic        nan_p0, vld_p0;
  logic [31:0] diff_p1;
  logic        nan_p1, vld_p1;

  // Monotonic integer key: -0 folds onto +0 so both zeros map to the same key.
  function automatic logic [31:0] fp_key(input logic [31:0] x);
    logic [31:0] z;
    z = (x == 32'h8000_0000) ? 32'h0 : x;
    return z[31] ? ~z : (z ^ 32'h8000_0000);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                              input logic [31:0] d);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + {{(ACC_W-31){1'b0}}, d};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
      RUN:  if ((acc_cnt == n_lat) && !vld_p0 && !vld_p1) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN) && (acc_cnt < n_lat);
    busy     = (state == RUN) || (state == DONE);
    done     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_lat   <= '0;
      acc_cnt <= '0;
    end else if (state == IDLE && start) begin
      n_lat   <= num_samples;
      acc_cnt <= '0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + 1'b1;
    end
  end

  // Stage p0: operand keys and NaN detection
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    key_e_p0 <= fp_key(exact);
    key_a_p0 <= fp_key(approx);
    nan_p0   <= is_nan(exact) || is_nan(approx);
  end

  // Stage p1: absolute key distance
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    diff_p1 <= abs_diff(key_e_p0, key_a_p0);
    nan_p1  <= nan_p0;
  end

  // Statistics update, one cycle after p1
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      nan_cnt      <= '0;
      max_ulp      <= '0;
      sum_ulp      <= '0;
    end else if (state == IDLE && start) begin
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      nan_cnt      <= '0;
      max_ulp      <= '0;
      sum_ulp      <= '0;
    end else if (vld_p1) begin
      sample_cnt <= sample_cnt + 1'b1;
      if (nan_p1) begin
        nan_cnt <= nan_cnt + 1'b1;
      end else begin
        sum_ulp <= sat_add(sum_ulp, diff_p1);
        if (diff_p1 > max_ulp) max_ulp <= diff_p1;
        if (diff_p1 != 32'h0) mismatch_cnt <= mismatch_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_err_monitor.sv
// Directed bench for fp_err_monitor: hand-computed ULP statistics, done timing and reset behaviour.
module tb_fp_err_monitor;
  localparam int CNT_W = 16;
  localparam int ACC_W = 48;

  logic             clk = 1'b0;
  logic             rst, start, in_valid;
  logic [CNT_W-1:0] num_samples;
  logic [31:0]      exact, approx;
  logic             in_ready, busy, done;
  logic [CNT_W-1:0] sample_cnt, mismatch_cnt, nan_cnt;
  logic [31:0]      max_ulp;
  logic [ACC_W-1:0] sum_ulp;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  logic [31:0] ex_v [8];
  logic [31:0] ap_v [8];

  fp_err_monitor #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .exact(exact), .approx(approx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt),
    .nan_cnt(nan_cnt), .max_ulp(max_ulp), .sum_ulp(sum_ulp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input int s, input int m, input int nn,
                           input logic [31:0] mx, input logic [63:0] sm);
    chk({tag, ".sample_cnt"}, 64'(sample_cnt), 64'(s));
    chk({tag, ".mismatch_cnt"}, 64'(mismatch_cnt), 64'(m));
    chk({tag, ".nan_cnt"}, 64'(nan_cnt), 64'(nn));
    chk({tag, ".max_ulp"}, 64'(max_ulp), 64'(mx));
    chk({tag, ".sum_ulp"}, 64'(sum_ulp), sm);
  endtask

  task automatic run(input string tag, input int n, input bit gaps);
    int idx, guard, k, d0;
    bit acc;
    d0 = done_seen;
    num_samples = CNT_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 200) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      exact  = ex_v[idx];
      approx = ap_v[idx];
      acc = in_valid && in_ready;
      tick();
      guard++;
      if (acc) idx++;
    end
    in_valid = 1'b1;
    chk({tag, ".accepts"}, 64'(idx), 64'(n));
    chk({tag, ".ready_after_n"}, 64'(in_ready), 64'd0);
    k = 0;
    do begin
      tick();
      k++;
    end while (!done && k < 10);
    in_valid = 1'b0;
    chk({tag, ".done_latency"}, 64'(k), 64'd3);
    tick();
    chk({tag, ".done_pulses"}, 64'(done_seen - d0), 64'd1);
    chk({tag, ".busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0;
    exact = '0; approx = '0;
    tick(); tick();
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk_stats("rst", 0, 0, 0, 32'h0, 64'h0);
    rst = 1'b0;
    tick();

    // Identical pairs
    for (int i = 0; i < 4; i++) begin ex_v[i] = 32'h3F80_0000; ap_v[i] = 32'h3F80_0000; end
    run("same", 4, 1'b0);
    chk_stats("same", 4, 0, 0, 32'h0, 64'h0);

    // Small distances on both sides of 1.0
    ex_v[0] = 32'h3F80_0000; ap_v[0] = 32'h3F80_0003;
    ex_v[1] = 32'h3F80_0000; ap_v[1] = 32'h3F7F_FFFF;
    run("ulp", 2, 1'b0);
    chk_stats("ulp", 2, 2, 0, 32'h3, 64'h4);
    tick(); tick();
    chk_stats("hold", 2, 2, 0, 32'h3, 64'h4);

    // Signed zeros and a sign flip
    ex_v[0] = 32'h0000_0000; ap_v[0] = 32'h8000_0000;
    ex_v[1] = 32'h3F80_0000; ap_v[1] = 32'hBF80_0000;
    run("sign", 2, 1'b0);
    chk_stats("sign", 2, 1, 0, 32'h7F00_0001, 64'h7F00_0001);

    // NaN operands
    ex_v[0] = 32'h7FC0_0000; ap_v[0] = 32'h3F80_0000;
    ex_v[1] = 32'h3F80_0000; ap_v[1] = 32'h7FC0_0001;
    ex_v[2] = 32'h4000_0000; ap_v[2] = 32'h4000_0001;
    run("nan", 3, 1'b0);
    chk_stats("nan", 3, 1, 2, 32'h1, 64'h1);

    // Random in_valid gaps
    for (int i = 0; i < 5; i++) begin ex_v[i] = 32'h3F80_0000; ap_v[i] = 32'h3F80_0000; end
    ap_v[4] = 32'h3F80_0002;
    run("gaps", 5, 1'b1);
    chk_stats("gaps", 5, 1, 0, 32'h2, 64'h2);

    // Reset mid-run after two accepts
    begin
      int d0;
      d0 = done_seen;
      num_samples = 16'd5; start = 1'b1; tick(); start = 1'b0;
      exact = 32'h3F80_0000; approx = 32'h3F80_0001; in_valid = 1'b1;
      tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0;
      chk("midrst.busy", 64'(busy), 64'd0);
      chk("midrst.in_ready", 64'(in_ready), 64'd0);
      chk_stats("midrst", 0, 0, 0, 32'h0, 64'h0);
      for (int i = 0; i < 6; i++) tick();
      chk("midrst.no_done", 64'(done_seen - d0), 64'd0);
      chk("midrst.sample_cnt_late", 64'(sample_cnt), 64'd0);

      num_samples = 16'd0; start = 1'b1; tick(); start = 1'b0;
      chk("zero.done", 64'(done), 64'd1);
      chk("zero.busy", 64'(busy), 64'd1);
      chk_stats("zero", 0, 0, 0, 32'h0, 64'h0);
      tick();
      chk("zero.done_pulses", 64'(done_seen - d0), 64'd1);
      chk("zero.idle", 64'(busy), 64'd0);
    end

    // rst wins over a simultaneous start
    rst = 1'b1; start = 1'b1; num_samples = 16'd3; tick();
    rst = 1'b0; start = 1'b0;
    chk("rststart.busy", 64'(busy), 64'd0);
    tick();
    chk("rststart.busy_later", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
